// File: rtl/cv32e40n_apu_resp_pkg.sv
// rtl/cv32e40n_apu_resp_pkg.sv - op encoding, FIFO entry type and result function for the APU responder
package cv32e40n_apu_resp_pkg;
    import cv32e40p_apu_core_pkg::*;

    localparam int APU_RESP_CNT_W = 8;

    typedef enum logic [APU_WOP_CPU-1:0] {
        APU_OP_ADD  = 6'd0,
        APU_OP_SUB  = 6'd1,
        APU_OP_XOR  = 6'd2,
        APU_OP_PASS = 6'd3
    } apu_resp_op_e;

    typedef struct packed {
        logic [31:0]                 result;
        logic [APU_NUSFLAGS_CPU-1:0] flags;
        logic [APU_RESP_CNT_W-1:0]   cnt;
    } apu_resp_entry_t;

    function automatic logic [31:0] apu_resp_compute(
        input logic [APU_WOP_CPU-1:0] op,
        input logic [31:0]            op_a,
        input logic [31:0]            op_b
    );
        logic [31:0] res;
        res = '0;
        case (apu_resp_op_e'(op))
            APU_OP_ADD:  res = op_a + op_b;
            APU_OP_SUB:  res = op_a - op_b;
            APU_OP_XOR:  res = op_a ^ op_b;
            APU_OP_PASS: res = op_a;
            default:     res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// rtl/cv32e40p_apu_core_pkg.sv - APU interface width constants shared with the core
package cv32e40p_apu_core_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

endpackage

// File: rtl/cv32e40n_apu_resp_fifo.sv
// rtl/cv32e40n_apu_resp_fifo.sv - in-order result FIFO with a per-entry latency countdown
module cv32e40n_apu_resp_fifo
    import cv32e40n_apu_resp_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  apu_resp_entry_t push_entry_i,
    input  logic            pop_i,
    output logic            head_due_o,
    output apu_resp_entry_t head_entry_o,
    output logic [CW-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apu_resp_entry_t mem_q [DEPTH];
    apu_resp_entry_t mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign head_entry_o = mem_q[rd_ptr_q];
    assign head_due_o   = (count_q != '0) && (mem_q[rd_ptr_q].cnt == '0);
    assign count_o      = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Stale slots saturate at zero, so ticking every slot is equivalent to ticking valid ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].cnt != '0) begin
                mem_d[i].cnt = mem_q[i].cnt - APU_RESP_CNT_W'(1);
            end
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cv32e40n_apu_responder.sv
// rtl/cv32e40n_apu_responder.sv - fixed-latency APU responder; optional grant stalls via CV32E40N_APU_RESP_STALL_EN
module cv32e40n_apu_responder
    import cv32e40p_apu_core_pkg::*;
    import cv32e40n_apu_resp_pkg::*;
#(
    parameter int LATENCY      = 1,
    parameter int DEPTH        = 2,
    parameter int STALL_PERIOD = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_i,
    input  logic [APU_WOP_CPU-1:0]              apu_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]         apu_flags_i,
    input  logic                                apu_req_i,
    output logic                                apu_gnt_o,
    output logic                                apu_rvalid_o,
    output logic [31:0]                         apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic            head_due;
    apu_resp_entry_t head_entry;
    apu_resp_entry_t push_entry;
    logic [CW-1:0]   count;
    logic            accept;
    logic            stall;
    logic            unused_inputs;

    assign unused_inputs = ^{apu_flags_i, apu_operands_i, head_entry.cnt};

`ifdef CV32E40N_APU_RESP_STALL_EN
    localparam int SW = $clog2(STALL_PERIOD);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = (stall_cnt_q == SW'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + SW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall = (stall_cnt_q == SW'(STALL_PERIOD - 1));
`else
    assign stall = 1'b0;
`endif

    // Outputs are masked by rst_ni so the reset cycle itself presents an idle interface.
    always_comb begin
        apu_gnt_o    = rst_ni && !stall && ((count < CW'(DEPTH)) || head_due);
        accept       = apu_req_i && apu_gnt_o;
        apu_rvalid_o = rst_ni && head_due;
        apu_result_o = apu_rvalid_o ? head_entry.result : '0;
        apu_flags_o  = apu_rvalid_o ? head_entry.flags : '0;

        push_entry          = '0;
        push_entry.result   = apu_resp_compute(apu_op_i, apu_operands_i[0], apu_operands_i[1]);
        push_entry.flags[0] = (push_entry.result == '0);
        push_entry.cnt      = APU_RESP_CNT_W'(LATENCY - 1);
    end

    cv32e40n_apu_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (accept),
        .push_entry_i (push_entry),
        .pop_i        (head_due),
        .head_due_o   (head_due),
        .head_entry_o (head_entry),
        .count_o      (count)
    );

endmodule

// File: tb/tb_cv32e40n_apu_responder.sv
// tb/tb_cv32e40n_apu_responder.sv - three responder configurations against a due-time queue model
module tb_cv32e40n_apu_responder;
    import cv32e40p_apu_core_pkg::*;

    localparam int NI = 3;
    localparam int LAT [NI] = '{3, 1, 4};
    localparam int DEP [NI] = '{4, 1, 2};
    localparam int SP = 4;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [APU_NARGS_CPU-1:0][31:0] ops;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    dflags;
    logic                           req;
    logic                           gnt    [NI];
    logic                           rvalid [NI];
    logic [31:0]                    res    [NI];
    logic [APU_NUSFLAGS_CPU-1:0]    flg    [NI];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cv32e40n_apu_responder #(.LATENCY(3), .DEPTH(4), .STALL_PERIOD(SP)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .apu_operands_i(ops), .apu_op_i(op), .apu_flags_i(dflags),
        .apu_req_i(req), .apu_gnt_o(gnt[0]), .apu_rvalid_o(rvalid[0]), .apu_result_o(res[0]),
        .apu_flags_o(flg[0]));
    cv32e40n_apu_responder #(.LATENCY(1), .DEPTH(1), .STALL_PERIOD(SP)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .apu_operands_i(ops), .apu_op_i(op), .apu_flags_i(dflags),
        .apu_req_i(req), .apu_gnt_o(gnt[1]), .apu_rvalid_o(rvalid[1]), .apu_result_o(res[1]),
        .apu_flags_o(flg[1]));
    cv32e40n_apu_responder #(.LATENCY(4), .DEPTH(2), .STALL_PERIOD(SP)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .apu_operands_i(ops), .apu_op_i(op), .apu_flags_i(dflags),
        .apu_req_i(req), .apu_gnt_o(gnt[2]), .apu_rvalid_o(rvalid[2]), .apu_result_o(res[2]),
        .apu_flags_o(flg[2]));

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got 0x%08h expected 0x%08h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input int o, input logic [31:0] a, input logic [31:0] b);
        if (o == 0) return a + b;
        if (o == 1) return a - b;
        if (o == 2) return a ^ b;
        if (o == 3) return a;
        return 32'd0;
    endfunction

    // Model: each accepted request becomes (instance, due cycle, result); it answers exactly at its due cycle.
    typedef struct {
        int          inst;
        int          due;
        logic [31:0] r;
    } pend_t;

    pend_t pend [$];
    int    cyc   = 0;
    int    phase = 0;

    always @(negedge clk) begin
        logic        exp_gnt [NI];
        logic        exp_pop [NI];
        logic [31:0] exp_res [NI];
        int          n;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk("rst_gnt", i, 32'(gnt[i]), 32'd0);
                chk("rst_rvalid", i, 32'(rvalid[i]), 32'd0);
                chk("rst_result", i, res[i], 32'd0);
                chk("rst_flags", i, 32'(flg[i]), 32'd0);
            end
            pend.delete();
            phase = 0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                n          = 0;
                exp_pop[i] = 1'b0;
                exp_res[i] = 32'd0;
                foreach (pend[k]) begin
                    if (pend[k].inst == i) begin
                        if (n == 0 && pend[k].due == cyc) begin
                            exp_pop[i] = 1'b1;
                            exp_res[i] = pend[k].r;
                        end
                        n++;
                    end
                end
                exp_gnt[i] = (n < DEP[i]) || exp_pop[i];
`ifdef CV32E40N_APU_RESP_STALL_EN
                if (phase == SP - 1) exp_gnt[i] = 1'b0;
`endif
                chk("gnt", i, 32'(gnt[i]), 32'(exp_gnt[i]));
                chk("rvalid", i, 32'(rvalid[i]), 32'(exp_pop[i]));
                chk("result", i, res[i], exp_res[i]);
                chk("flags", i, 32'(flg[i]), (exp_pop[i] && exp_res[i] == 0) ? 32'd1 : 32'd0);
            end
            for (int i = 0; i < NI; i++) begin
                if (exp_pop[i]) begin
                    for (int k = 0; k < pend.size(); k++) begin
                        if (pend[k].inst == i) begin
                            pend.delete(k);
                            break;
                        end
                    end
                end
                if (req && exp_gnt[i]) begin
                    pend.push_back('{i, cyc + LAT[i], ref_result(int'(op), ops[0], ops[1])});
                end
            end
            phase = (phase + 1) % SP;
        end
        cyc++;
    end

    task automatic step(input logic r, input logic q, input int o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        rst_n  = r;
        req    = q;
        op     = APU_WOP_CPU'(o);
        ops[0] = a;
        ops[1] = b;
        ops[2] = $urandom;
        dflags = APU_NDSFLAGS_CPU'($urandom);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          dens;
        rst_n  = 1'b0;
        req    = 1'b1;
        op     = '0;
        ops    = '0;
        dflags = '0;

        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 0, 32'd1, 32'd2);
            @(negedge clk);
            for (int i = 0; i < NI; i++) chk("lit_rst_gnt", i, 32'(gnt[i]), 32'd0);
        end

        step(1'b1, 1'b1, 0, 32'd5, 32'd7);
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk("lit_first_gnt", i, 32'(gnt[i]), 32'd1);
        step(1'b1, 1'b1, 1, 32'd3, 32'd3);
        @(negedge clk);
        chk("lit_add_early", 0, 32'(rvalid[0]), 32'd0);
        chk("lit_l1_rvalid", 1, 32'(rvalid[1]), 32'd1);
        chk("lit_l1_add", 1, res[1], 32'd12);
        chk("lit_l1_full_gnt", 1, 32'(gnt[1]), 32'd1);
        step(1'b1, 1'b0, 0, 32'd0, 32'd0);
        @(negedge clk);
        chk("lit_add_early2", 0, 32'(rvalid[0]), 32'd0);
        chk("lit_l1_sub_flag", 1, 32'(flg[1]), 32'd1);
        step(1'b1, 1'b0, 0, 32'd0, 32'd0);
        @(negedge clk);
        chk("lit_add_rvalid", 0, 32'(rvalid[0]), 32'd1);
        chk("lit_add_result", 0, res[0], 32'd12);
        chk("lit_add_flag", 0, 32'(flg[0]), 32'd0);
        step(1'b1, 1'b0, 0, 32'd0, 32'd0);
        @(negedge clk);
        chk("lit_sub_result", 0, res[0], 32'd0);
        chk("lit_sub_flag", 0, 32'(flg[0]), 32'd1);

        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 0, 32'd0, 32'd0);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1, 32'(k), 32'd1);
            @(negedge clk);
`ifndef CV32E40N_APU_RESP_STALL_EN
            chk("lit_l1_stream_gnt", 1, 32'(gnt[1]), 32'd1);
            chk("lit_l4d2_gnt", 2, 32'(gnt[2]), (k % 4 < 2) ? 32'd1 : 32'd0);
`endif
        end

        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 0, 32'd9, 32'd9);
        step(1'b1, 1'b1, 2, 32'd9, 32'd8);
        step(1'b0, 1'b0, 0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 0, 32'd0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 0, 32'd0, 32'd0);
            @(negedge clk);
            for (int i = 0; i < NI; i++) chk("lit_flush_rvalid", i, 32'(rvalid[i]), 32'd0);
        end
        step(1'b1, 1'b1, 3, 32'h1234_5678, 32'd0);

        dens = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) dens = $urandom_range(10, 100);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
            step(($urandom_range(0, 299) != 0), ($urandom_range(1, 100) <= dens),
                 $urandom_range(0, 7), a, b);
        end
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
